rs232_rx_core: RTL and testbench

RS232_RX_CORE -- requirements
Module: rs232_rx_core

---
 rtl/rs232_rx_core.sv | 228 ++++++++++++++++++++++
 tb/tb_rs232_rx_core.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_rx_core.sv
// ============================================================================
// Module   : rs232_rx_core
// Brief    : Oversampling-free RS-232 receiver with parity check, sticky error
//            flags and a first-word-fall-through receive FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rs232_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic                          rx_done,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(4);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  state_t               state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [1:0]           pm_q, pm_d;
  logic [BIT_W-1:0]     bits_q, bits_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 push_q, push_d;
  logic                 set_perr, set_ferr;
  logic                 par_exp;
  logic                 sample_mid;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 full, pop, push_ok, drop;
  logic                 ferr_q, perr_q, ovr_q;

  // Line synchroniser; rx_prev_q gives the 1->0 edge used for start detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= DIV_MIN;
      pm_q      <= 2'b00;
      bits_q    <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      push_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pm_q      <= pm_d;
      bits_q    <= bits_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      push_q    <= push_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pm_d       = pm_q;
    bits_d     = bits_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    push_d     = 1'b0;
    set_perr   = 1'b0;
    set_ferr   = 1'b0;
    par_exp    = (pm_q == 2'b10) ? ~(^shift_q) : (^shift_q);
    sample_mid = (cnt_q == div_q - DIV_W'(1));
    case (state_q)
      S_IDLE: begin
        // Edge, not level: a held-low break never re-triggers a start.
        if (rx_prev_q && !rx_s_q) begin
          cnt_d     = '0;
          div_d     = (baud_div < DIV_MIN) ? DIV_MIN : baud_div;
          pm_d      = parity_mode;
          bits_d    = '0;
          par_bad_d = 1'b0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (cnt_q == (div_q >> 1)) begin
          cnt_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_DATA: begin
        if (sample_mid) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = '0;
          bits_d  = bits_q + BIT_W'(1);
          if (bits_q == LAST_BIT) begin
            state_d = (pm_q == 2'b01 || pm_q == 2'b10) ? S_PARITY : S_STOP;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_PARITY: begin
        if (sample_mid) begin
          if (rx_s_q != par_exp) begin
            par_bad_d = 1'b1;
            set_perr  = 1'b1;
          end
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_STOP: begin
        if (sample_mid) begin
          if (!rx_s_q) begin
            set_ferr = 1'b1;
          end else begin
            push_d = !par_bad_q;
          end
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign full    = (count_q == FULL_CNT);
  assign pop     = rd_en && (count_q != '0);
  assign push_ok = push_q && (!full || pop);
  assign drop    = push_q && full && !pop;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      if (err_clr) begin
        ferr_q <= 1'b0;
        perr_q <= 1'b0;
        ovr_q  <= 1'b0;
      end else begin
        if (set_ferr) ferr_q <= 1'b1;
        if (set_perr) perr_q <= 1'b1;
        if (drop)     ovr_q  <= 1'b1;
      end
    end
  end

  assign rd_valid   = (count_q != '0);
  assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign rx_done    = push_ok;
  assign fifo_count = count_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_rs232_rx_core.sv
// ============================================================================
// Module   : tb_rs232_rx_core
// Brief    : Scoreboard bench for rs232_rx_core with directed frames.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rs232_rx_core;

  localparam int BAUD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        rd_en;
  logic        err_clr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rx_done;
  logic        frame_err;
  logic        parity_err;
  logic        overrun;
  logic [2:0]  fifo_count;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int done_ref;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  rs232_rx_core #(.DATA_BITS(8), .DIV_W(16), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .baud_div   (baud_div),
    .parity_mode(parity_mode),
    .rd_en      (rd_en),
    .err_clr    (err_clr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .fifo_count (fifo_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts done pulses and checks every popped word against the queue.
  always @(negedge clk) begin
    if (rst) begin
      if (rx_done) done_cnt++;
      if (rd_en && rd_valid) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
        end else begin
          check("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(BAUD);
  endtask

  task automatic idle(input int nbits);
    rx = 1'b1;
    tick(nbits * BAUD);
  endtask

  task automatic send_frame(input logic [7:0] d, input int pbit, input logic stopb);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pbit >= 0) send_bit(pbit[0]);
    send_bit(stopb);
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      tick(1);
    end
  endtask

  task automatic clear_errs;
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
  endtask

  initial begin
    rst = 1'b0; rx = 1'b1; baud_div = 16'(BAUD); parity_mode = 2'b00;
    rd_en = 1'b0; err_clr = 1'b0;
    tick(3);
    check("rst_rd_valid",   32'(rd_valid),   0);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_rd_data",    32'(rd_data),    0);
    check("rst_flags",      32'({frame_err, parity_err, overrun, rx_done}), 0);
    rst = 1'b1;
    idle(2);

    // Plain 8N1 frame.
    done_ref = done_cnt;
    exp_q.push_back(8'h55);
    send_frame(8'h55, -1, 1'b1);
    idle(2);
    check("f55_rd_valid", 32'(rd_valid), 1);
    check("f55_rd_data",  32'(rd_data),  32'h55);
    check("f55_done",     32'(done_cnt - done_ref), 1);
    check("f55_flags",    32'({frame_err, parity_err, overrun}), 0);
    read_n(1);
    check("f55_empty", 32'(fifo_count), 0);

    // Short low glitch must be rejected as a false start.
    done_ref = done_cnt;
    rx = 1'b0; tick(3); idle(4);
    check("glitch_count", 32'(fifo_count), 0);
    check("glitch_done",  32'(done_cnt - done_ref), 0);
    check("glitch_flags", 32'({frame_err, parity_err, overrun}), 0);

    // Even parity, 0xA5 has four ones: correct bit 0, send 1.
    parity_mode = 2'b01;
    send_frame(8'hA5, 1, 1'b1);
    idle(2);
    check("par_err_set",  32'(parity_err), 1);
    check("par_fifo",     32'(fifo_count), 0);
    clear_errs();
    check("par_err_clr",  32'(parity_err), 0);

    // Odd parity, 0x3F has six ones: parity bit 1 is correct.
    parity_mode = 2'b10;
    exp_q.push_back(8'h3F);
    send_frame(8'h3F, 1, 1'b1);
    parity_mode = 2'b00;
    idle(2);
    check("odd_ok_count", 32'(fifo_count), 1);
    check("odd_ok_perr",  32'(parity_err), 0);
    read_n(1);

    // Stop bit 0 followed by a long break: one detection, nothing pushed.
    done_ref = done_cnt;
    send_frame(8'h12, -1, 1'b0);
    rx = 1'b0;
    tick(2 * BAUD);
    check("brk_ferr", 32'(frame_err), 1);
    clear_errs();
    tick(28 * BAUD);
    check("brk_no_redetect", 32'(frame_err), 0);
    check("brk_fifo",        32'(fifo_count), 0);
    idle(3);
    exp_q.push_back(8'h81);
    send_frame(8'h81, -1, 1'b1);
    idle(2);
    check("brk_recover_done", 32'(done_cnt - done_ref), 1);
    read_n(1);

    // Five frames with no reads: fifth dropped with overrun.
    done_ref = done_cnt;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_frame(8'(i), -1, 1'b1);
      idle(2);
    end
    check("ovr_count", 32'(fifo_count), 4);
    check("ovr_flag",  32'(overrun), 1);
    check("ovr_done",  32'(done_cnt - done_ref), 4);
    read_n(4);
    check("ovr_drained", 32'(fifo_count), 0);
    rd_en = 1'b1; tick(1); rd_en = 1'b0; tick(1);
    check("underflow", 32'(fifo_count), 0);
    clear_errs();
    check("ovr_clr", 32'(overrun), 0);

    // Reset in the middle of the data bits; only the following frame lands.
    done_ref = done_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    rx = 1'b0; tick(3);
    rst = 1'b0; tick(2);
    rx = 1'b1; tick(2);
    rst = 1'b1;
    idle(3);
    check("mid_rst_count", 32'(fifo_count), 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, -1, 1'b1);
    idle(2);
    check("mid_rst_done",  32'(done_cnt - done_ref), 1);
    check("mid_rst_data",  32'(rd_data), 32'h3C);
    read_n(1);

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
